// File: rtl/encoder8x3_seq.sv
// encoder8x3_seq -- sequential 8:3 encoder.
//
// Captures request events on 8 lines into a pending register and emits one
// 3-bit index per valid/ready handshake. The served bit is cleared when its
// index is loaded into the output register. The index is meant to be
// re-decoded by the 3:8 decoder downstream (code[2] = decoder input a).
//
// Parameters:
//   EDGE_DET  1: an event is a rising edge of req; 0: an event is a high req level.
// Build macro:
//   ENC_ROUND_ROBIN_EN  defined: round-robin winner after the last loaded index.
//                       undefined: fixed priority, highest index wins.
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   req      [7:0] request lines
//   clr_ovf  synchronous clear of ovf (a new overflow in the same cycle wins)
//   code     [2:0] encoded index, meaningful while valid
//   valid    code holds an unserved index
//   ready    consumer accepts code on valid && ready
//   pending  [7:0] captured requests not yet loaded into code
//   ovf      sticky: an event hit a bit that was already pending
module encoder8x3_seq #(
  parameter bit EDGE_DET = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       clr_ovf,
  output logic [2:0] code,
  output logic       valid,
  input  logic       ready,
  output logic [7:0] pending,
  output logic       ovf
);

  localparam int N  = 8;
  localparam int IW = 3;

  typedef enum logic {EMPTY, FULL} state_t;

  state_t          state, state_nx;
  logic [N-1:0]    req_d;
  logic [N-1:0]    ev;
  logic [N-1:0]    load_mask;
  logic [N-1:0]    pend_nx;
  logic [IW-1:0]   win;
  logic            load;

  assign ev    = EDGE_DET ? (req & ~req_d) : req;
  assign valid = (state == FULL);

  // Winner is picked from the registered pending value, i.e. before this
  // edge's events are merged in.
`ifdef ENC_ROUND_ROBIN_EN
  logic [IW-1:0] rr_ptr;

  // Walk downward over the search distance so the nearest set bit after
  // rr_ptr (distance 1) is written last and wins; distance 8 is rr_ptr itself.
  always_comb begin
    win = '0;
    for (int k = N; k >= 1; k--) begin
      if (pending[rr_ptr + IW'(k)]) win = rr_ptr + IW'(k);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    rr_ptr <= IW'(N - 1);
    else if (load) rr_ptr <= win;
  end
`else
  // Ascending scan: the highest set index is written last and wins.
  always_comb begin
    win = '0;
    for (int i = 0; i < N; i++) begin
      if (pending[i]) win = IW'(i);
    end
  end
`endif

  // Output register is free when empty, or when full and being accepted;
  // a load in the accept cycle gives back-to-back indices with no bubble.
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    case (state)
      EMPTY: begin
        if (|pending) begin
          load     = 1'b1;
          state_nx = FULL;
        end
      end
      FULL: begin
        if (ready) begin
          if (|pending) load = 1'b1;
          else          state_nx = EMPTY;
        end
      end
      default: state_nx = EMPTY;
    endcase
  end

  assign load_mask = load ? (N'(1) << win) : '0;
  // Set wins: a fresh event on the bit being loaded keeps it pending.
  assign pend_nx   = (pending & ~load_mask) | ev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= EMPTY;
      code    <= '0;
      pending <= '0;
      req_d   <= '0;
      ovf     <= 1'b0;
    end else begin
      state   <= state_nx;
      pending <= pend_nx;
      req_d   <= req;
      if (load) code <= win;
      if (|(ev & pending & ~load_mask)) ovf <= 1'b1;
      else if (clr_ovf)                 ovf <= 1'b0;
    end
  end

endmodule
